// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-entry data memory responder with byte/half/word access
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  minst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_nx;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_q;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        err_q;

    logic          accept;
    logic          is_store;
    logic [2:0]    f3;
    logic [AW-1:0] idx;
    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    assign rsp_valid = (state == RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign is_store  = minst[3];
    assign f3        = minst[2:0];
    assign idx       = addr[AW+1:2];
    assign rsp_err   = err_q;

    // Request legality: alignment, encodable funct3, store size and address range
    always_comb begin
        bad = 1'b0;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = (addr[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
        if (is_store && f3[2]) bad = 1'b1;
        if (addr[31:AW+2] != '0) bad = 1'b1;
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be   = 4'b0000;
        wrep = wdata;
        case (f3[1:0])
            2'b00: begin
                be   = 4'b0001 << addr[1:0];
                wrep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be   = addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata;
            end
        endcase
    end

    // FSM state register; reset drops any pending response immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: a new accept always refills the single response slot
    always_comb begin
        state_nx = state;
        if (accept)         state_nx = RESP;
        else if (rsp_ready) state_nx = IDLE;
    end

    // Response attributes captured only on accept so they hold while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q  <= 1'b0;
            load_q <= 1'b0;
            lane_q <= 2'b00;
            f3_q   <= 3'b000;
        end else if (accept) begin
            err_q  <= bad;
            load_q <= !bad && !is_store;
            lane_q <= addr[1:0];
            f3_q   <= f3;
        end
    end

    // SRAM port: write or read on the accepting edge only; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && !bad && is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wrep[i*8 +: 8];
            end
        end
        if (accept && !bad && !is_store) rd_q <= mem[idx];
    end

    // Saturating count of error responses actually handed over
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        err_count <= 8'd0;
        else if (rsp_valid && rsp_ready && err_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end

    // Load result extraction from the registered word, lane and size
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = rd_q[7:0];
            2'd1:    byte_sel = rd_q[15:8];
            2'd2:    byte_sel = rd_q[23:16];
            default: byte_sel = rd_q[31:24];
        endcase
        half_sel  = lane_q[1] ? rd_q[31:16] : rd_q[15:0];
        rsp_rdata = 32'd0;
        if (load_q) begin
            case (f3_q[1:0])
                2'b00:   rsp_rdata = {{24{byte_sel[7] & !f3_q[2]}}, byte_sel};
                2'b01:   rsp_rdata = {{16{half_sel[15] & !f3_q[2]}}, half_sel};
                default: rsp_rdata = rd_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven scoreboard bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  minst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;

    dmem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .minst     (minst),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count)
    );

    typedef struct {
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          lat;
        int          stamp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                if (e.lat) check("latency", cyc, e.stamp);
                if (e.err && exp_errs < 255) exp_errs++;
            end
        end
    end

    task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] er, input logic ee, input bit lat);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        req_valid = 1'b1;
        minst = m;
        addr  = a;
        wdata = w;
        while (!done && n < 20) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back('{er, ee, lat, cyc + 1});
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        minst     = 4'd0;
        addr      = 32'd0;
        wdata     = 32'd0;

        vecs.push_back('{4'hA, 32'h10,   32'h8000_7F01, 32'h0,          1'b0});
        vecs.push_back('{4'h2, 32'h10,   32'h0,         32'h8000_7F01, 1'b0});
        vecs.push_back('{4'h0, 32'h10,   32'h0,         32'h0000_0001, 1'b0});
        vecs.push_back('{4'h0, 32'h13,   32'h0,         32'hFFFF_FF80, 1'b0});
        vecs.push_back('{4'h4, 32'h13,   32'h0,         32'h0000_0080, 1'b0});
        vecs.push_back('{4'h1, 32'h10,   32'h0,         32'h0000_7F01, 1'b0});
        vecs.push_back('{4'h5, 32'h12,   32'h0,         32'h0000_8000, 1'b0});
        vecs.push_back('{4'hA, 32'h20,   32'h1111_1111, 32'h0,          1'b0});
        vecs.push_back('{4'h8, 32'h21,   32'h0000_00AB, 32'h0,          1'b0});
        vecs.push_back('{4'h2, 32'h20,   32'h0,         32'h1111_AB11, 1'b0});
        vecs.push_back('{4'h9, 32'h22,   32'h0000_BEEF, 32'h0,          1'b0});
        vecs.push_back('{4'h1, 32'h22,   32'h0,         32'hFFFF_BEEF, 1'b0});
        vecs.push_back('{4'h2, 32'h20,   32'h0,         32'hBEEF_AB11, 1'b0});
        vecs.push_back('{4'hA, 32'h0,    32'h1234_5678, 32'h0,          1'b0});
        vecs.push_back('{4'h2, 32'h22,   32'h0,         32'h0,          1'b1});
        vecs.push_back('{4'h9, 32'h03,   32'h0000_FFFF, 32'h0,          1'b1});
        vecs.push_back('{4'h3, 32'h0,    32'h0,         32'h0,          1'b1});
        vecs.push_back('{4'h2, 32'h1000, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{4'hC, 32'h20,   32'hFFFF_FFFF, 32'h0,          1'b1});
        vecs.push_back('{4'hA, 32'h1000, 32'hDEAD_BEEF, 32'h0,          1'b1});
        vecs.push_back('{4'h2, 32'h0,    32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{4'h2, 32'h20,   32'h0,         32'hBEEF_AB11, 1'b0});
        vecs.push_back('{4'h2, 32'h10,   32'h0,         32'h8000_7F01, 1'b0});

        #12;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            issue(vecs[i].m, vecs[i].a, vecs[i].w, vecs[i].er, vecs[i].ee, 1'b1);
        drain();
        check("err_count_table", {24'd0, err_count}, exp_errs);

        // Stall: pending load held while a second request waits
        rsp_ready = 1'b0;
        issue(4'h2, 32'h10, 32'h0, 32'h8000_7F01, 1'b0, 1'b0);
        req_valid = 1'b1;
        minst = 4'h2;
        addr  = 32'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'h8000_7F01);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(4'h2, 32'h20, 32'h0, 32'hBEEF_AB11, 1'b0, 1'b1);
        drain();

        // Saturation of the error counter
        for (int k = 0; k < 260; k++)
            issue(4'h3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        drain();
        check("err_count_sat", {24'd0, err_count}, exp_errs);
        check("err_count_255", {24'd0, err_count}, 32'd255);

        // Asynchronous reset with a response pending
        rsp_ready = 1'b0;
        issue(4'h2, 32'h20, 32'h0, 32'hBEEF_AB11, 1'b0, 1'b0);
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("async_rst_err_count", {24'd0, err_count}, 32'd0);
        check("async_rst_rdata", rsp_rdata, 32'd0);
        sb.delete();
        exp_errs = 0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(4'h2, 32'h20, 32'h0, 32'hBEEF_AB11, 1'b0, 1'b1);
        issue(4'h1, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
